// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg
// ---------------------------------------------------------------------------
// MEM/WB pipeline register. It holds one instruction between the memory stage
// and the write-back stage and exchanges entries with both stages through a
// valid/ready handshake. It also selects the final write-back value and counts
// back-pressure cycles.
//
// Build option:
//   MEM_WB_SKID_EN  defined     -> two-entry buffer (main + skid register).
//                                  in_ready comes straight from the skid
//                                  valid flop.
//                   not defined -> single entry. in_ready = !out_valid |
//                                  out_ready.
//
// Parameters: DATA_W (data/PC width), RD_W (register index width),
//             CNT_W (stall counter width)
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               squash every held entry
//   in_valid/in_ready   MEM-side handshake
//   rd, read_data, alu_result, pc, reg_write, mem_to_reg
//                       incoming entry payload
//   out_valid/out_ready WB-side handshake
//   rd_out, read_out, alu_out, pc_out, mem_to_reg_out
//                       payload of the main register
//   reg_write_out       stored reg_write qualified by out_valid
//   wb_data             load data or ALU result, selected by mem_to_reg_out
//   stall_cnt           saturating count of out_valid & !out_ready cycles
// ---------------------------------------------------------------------------
module mem_wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   rd_out,
  output logic [DATA_W-1:0] read_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc;
    logic              rw;
    logic              m2r;
  } entry_t;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  entry_t           in_ent;
  entry_t           main_q, main_d;
  logic             main_vld_q, main_vld_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             xfer;

  assign in_ent = {rd, read_data, alu_result, pc, reg_write, mem_to_reg};

`ifdef MEM_WB_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_vld_q, skid_vld_d;

  // Driven only by the skid flop (and rst), so the MEM stage never sees a
  // combinational path from out_ready.
  assign in_ready = !skid_vld_q && !rst;
`else
  assign in_ready = (!main_vld_q || out_ready) && !rst;
`endif

  assign accept = in_valid && in_ready && !flush && !rst;
  assign xfer   = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
`ifdef MEM_WB_SKID_EN
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
`endif
    stall_d    = stall_q;

    if (main_vld_q && !out_ready && !flush) begin
      stall_d = sat_inc(stall_q);
    end

    // Flush drops the valid bits only. Payload flops keep their contents.
    if (flush) begin
      main_vld_d = 1'b0;
`ifdef MEM_WB_SKID_EN
      skid_vld_d = 1'b0;
`endif
    end else begin
`ifdef MEM_WB_SKID_EN
      if (skid_vld_q) begin
        // Buffer full: in_ready is low, so only the skid-to-main move is possible.
        if (xfer) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end
      end else if (accept) begin
        if (!main_vld_q || xfer) begin
          main_d     = in_ent;
          main_vld_d = 1'b1;
        end else begin
          skid_d     = in_ent;
          skid_vld_d = 1'b1;
        end
      end else if (xfer) begin
        main_vld_d = 1'b0;
      end
`else
      if (accept) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end else if (xfer) begin
        main_vld_d = 1'b0;
      end
`endif
    end
  end

  // ---- register stage: main (and skid) entry, stall counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      stall_q    <= '0;
`ifdef MEM_WB_SKID_EN
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
`endif
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      stall_q    <= stall_d;
`ifdef MEM_WB_SKID_EN
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
`endif
    end
  end

  assign out_valid      = main_vld_q;
  assign rd_out         = main_q.rd;
  assign read_out       = main_q.rdata;
  assign alu_out        = main_q.alu;
  assign pc_out         = main_q.pc;
  assign mem_to_reg_out = main_q.m2r;
  // The stored reg_write may be stale after a flush, so qualify it with valid.
  assign reg_write_out  = main_vld_q && main_q.rw;
  assign wb_data        = main_q.m2r ? main_q.rdata : main_q.alu;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
module tb_mem_wb_pipe_reg;

`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, reg_write, mem_to_reg;
  logic [4:0]  rd;
  logic [31:0] read_data, alu_result, pc;

  logic        in_ready, out_valid, reg_write_out, mem_to_reg_out;
  logic [4:0]  rd_out;
  logic [31:0] read_out, alu_out, pc_out, wb_data;
  logic [15:0] stall_cnt;

  logic        b_in_ready, b_out_valid, b_reg_write_out, b_mem_to_reg_out;
  logic [4:0]  b_rd_out;
  logic [31:0] b_read_out, b_alu_out, b_pc_out, b_wb_data;
  logic [1:0]  b_stall_cnt;

  mem_wb_pipe_reg #(.DATA_W(32), .RD_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .read_data(read_data), .alu_result(alu_result), .pc(pc),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .out_valid(out_valid),
    .out_ready(out_ready), .rd_out(rd_out), .read_out(read_out), .alu_out(alu_out),
    .pc_out(pc_out), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance, sharing the same stimulus.
  mem_wb_pipe_reg #(.DATA_W(32), .RD_W(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .rd(rd), .read_data(read_data), .alu_result(alu_result), .pc(pc),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .out_valid(b_out_valid),
    .out_ready(out_ready), .rd_out(b_rd_out), .read_out(b_read_out), .alu_out(b_alu_out),
    .pc_out(b_pc_out), .reg_write_out(b_reg_write_out), .mem_to_reg_out(b_mem_to_reg_out),
    .wb_data(b_wb_data), .stall_cnt(b_stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of entries plus stall counters.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        rw;
    logic        m2r;
  } ent_t;

  ent_t mq[$];
  int   c16 = 0;
  int   c2  = 0;
  bit   last_acc;

  function automatic bit model_ready();
    if (rst) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic logic [31:0] model_wb();
    return mq[0].m2r ? mq[0].rdata : mq[0].alu;
  endfunction

  task automatic tick();
    bit   acc, xf, st;
    ent_t e;
    e   = '{rd: rd, rdata: read_data, alu: alu_result, pc: pc, rw: reg_write, m2r: mem_to_reg};
    acc = in_valid && model_ready() && !flush && !rst;
    xf  = (mq.size() > 0) && out_ready;
    st  = (mq.size() > 0) && !out_ready && !flush;
    @(posedge clk);
    #1;
    last_acc = acc && !rst;
    if (rst) begin
      mq.delete();
      c16 = 0;
      c2  = 0;
    end else begin
      if (st) begin
        if (c16 < 65535) c16++;
        if (c2 < 3) c2++;
      end
      if (flush) mq.delete();
      else begin
        if (xf) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
  endtask

  task automatic rand_payload();
    rd         = 5'($urandom);
    read_data  = $urandom;
    alu_result = $urandom;
    pc         = $urandom;
    reg_write  = 1'($urandom);
    mem_to_reg = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rand_payload();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out: got %0d want 0", rd_out); end
    checks++; if (read_out !== 32'd0) begin errors++; $display("FAIL reset_read_out: got %h want 0", read_out); end
    checks++; if (alu_out !== 32'd0) begin errors++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL reset_reg_write_out: got %0b want 0", reg_write_out); end
    checks++; if (mem_to_reg_out !== 1'b0) begin errors++; $display("FAIL reset_mem_to_reg_out: got %0b want 0", mem_to_reg_out); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_rst: got %0b want 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %0b want 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; rd = 5'(i + 1); alu_result = 32'h10 + 32'(i);
      mem_to_reg = 1'b0; reg_write = 1'b1; read_data = $urandom; pc = $urandom;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid[%0d]: got %0b want 1", i, out_valid); end
      checks++; if (rd_out !== 5'(i + 1)) begin errors++; $display("FAIL stream_rd_out[%0d]: got %0d want %0d", i, rd_out, i + 1); end
      checks++; if (wb_data !== 32'h10 + 32'(i)) begin errors++; $display("FAIL stream_wb_data[%0d]: got %h want %h", i, wb_data, 32'h10 + 32'(i)); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt[%0d]: got %0d want 0", i, stall_cnt); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %0b want 0", out_valid); end
  endtask

  task automatic test_load();
    out_ready = 1'b1; flush = 1'b0;
    in_valid = 1'b1; rd = 5'd9; read_data = 32'hDEADBEEF; alu_result = 32'h4;
    pc = 32'h100; mem_to_reg = 1'b1; reg_write = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_wb_data: got %h want deadbeef", wb_data); end
    checks++; if (reg_write_out !== 1'b1) begin errors++; $display("FAIL load_reg_write_out: got %0b want 1", reg_write_out); end
    checks++; if (alu_out !== 32'h4) begin errors++; $display("FAIL load_alu_out: got %h want 4", alu_out); end
    tick();
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL load_reg_write_after: got %0b want 0", reg_write_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_out_valid_after: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int k;
    int got[$];
    int want_acc;
    int g;
    do_reset();
    k = 0;
    want_acc = SKID ? 2 : 1;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (k < 3);
      rd = 5'(5 + k); alu_result = 32'h100 + 32'(k); mem_to_reg = 1'b0; reg_write = 1'b1;
      tick();
      if (last_acc) k++;
    end
    #1;
    checks++; if (k != want_acc) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", k, want_acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
    checks++; if (rd_out !== 5'd5) begin errors++; $display("FAIL bp_head: got %0d want 5", rd_out); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
      in_valid = (k < 3);
      rd = 5'(5 + k); alu_result = 32'h100 + 32'(k);
      #1;
      if (out_valid) got.push_back(int'(rd_out));
      tick();
      if (last_acc) k++;
    end
    in_valid = 1'b0;
    checks++; if (k != 3) begin errors++; $display("FAIL bp_third_accepted: got %0d want 3", k); end
    for (int i = 0; i < 3; i++) begin
      g = (i < got.size()) ? got[i] : -1;
      checks++; if (g != 5 + i) begin errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, g, 5 + i); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; rd = 5'(10 + i); reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = $urandom;
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %0b want 1", out_valid); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_pre_stall: got %0d want 1", stall_cnt); end
    flush = 1'b1; in_valid = 1'b1; rd = 5'd12;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL flush_reg_write_out: got %0b want 0", reg_write_out); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_stall_cnt: got %0d want 1", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_entry_not_taken: got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    int w;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; reg_write = 1'b1; rd = 5'd3;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      w = (k < 3) ? k : 3;
      checks++; if (b_stall_cnt !== 2'(w)) begin errors++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", k, b_stall_cnt, w); end
    end
    checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL sat_cnt16: got %0d want 6", stall_cnt); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_midreset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rand_payload(); reg_write = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %0b want 0", in_ready); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL midrst_reg_write_out: got %0b want 0", reg_write_out); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL midrst_wb_data: got %h want 0", wb_data); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready_after: got %0b want 1", in_ready); end
  endtask

  task automatic test_random();
    bit exp_v;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(79) == 0);
      flush     = ($urandom_range(24) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      rand_payload();
      #1;
      checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL rand_in_ready[%0d]: got %0b want %0b", n, in_ready, model_ready()); end
      tick();
      exp_v = (mq.size() > 0);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rand_out_valid[%0d]: got %0b want %0b", n, out_valid, exp_v); end
      checks++; if (b_out_valid !== exp_v) begin errors++; $display("FAIL rand_out_valid2[%0d]: got %0b want %0b", n, b_out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rd_out !== mq[0].rd) begin errors++; $display("FAIL rand_rd_out[%0d]: got %0d want %0d", n, rd_out, mq[0].rd); end
        checks++; if (pc_out !== mq[0].pc) begin errors++; $display("FAIL rand_pc_out[%0d]: got %h want %h", n, pc_out, mq[0].pc); end
        checks++; if (wb_data !== model_wb()) begin errors++; $display("FAIL rand_wb_data[%0d]: got %h want %h", n, wb_data, model_wb()); end
        checks++; if (reg_write_out !== mq[0].rw) begin errors++; $display("FAIL rand_reg_write_out[%0d]: got %0b want %0b", n, reg_write_out, mq[0].rw); end
      end else begin
        checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL rand_reg_write_idle[%0d]: got %0b want 0", n, reg_write_out); end
      end
      checks++; if (stall_cnt !== 16'(c16)) begin errors++; $display("FAIL rand_stall_cnt[%0d]: got %0d want %0d", n, stall_cnt, c16); end
      checks++; if (b_stall_cnt !== 2'(c2)) begin errors++; $display("FAIL rand_stall_cnt2[%0d]: got %0d want %0d", n, b_stall_cnt, c2); end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rd = '0; read_data = '0; alu_result = '0; pc = '0; reg_write = 1'b0; mem_to_reg = 1'b0;
    test_reset();
    test_stream();
    test_load();
    test_backpressure();
    test_flush();
    test_saturation();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
